// File: rtl/ray_frame_scheduler.sv
// Frame coordinate sequencer for the ray-march pipeline.
// Issues one frame of (x,y) coordinates in raster order. In-flight rays are
// capped by a credit counter that is refilled as pixels leave the packer.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | offering coordinates to ray_unit
// DRAIN | all issues done (or aborted), waiting for in-flight rays to return
// DONE  | one-cycle frame completion, frame_done asserted
module ray_frame_scheduler #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 64,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             out_stream_aclk,
  input  logic             periph_resetn,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  output logic [9:0]       coord_x,
  output logic [8:0]       coord_y,
  output logic             coord_sof,
  output logic             coord_eol,
  output logic             coord_valid,
  input  logic             coord_ready,
  input  logic             credit_return,
  output logic [CNT_W-1:0] inflight,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic             err_underflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [9:0] x_nxt;
  logic [8:0] y_nxt;
  logic       stop_pend, stop_pend_nxt;
  logic       issue;
  logic       last_x, last_y;

  // Valid depends on registered credit state only; a credit returned this
  // cycle frees a slot next cycle.
  assign coord_valid = (state == S_RUN) && (inflight < CNT_W'(MAX_INFLIGHT));
  assign issue       = coord_valid && coord_ready;
  assign last_x      = (coord_x == 10'(H_RES - 1));
  assign last_y      = (coord_y == 9'(V_RES - 1));
  assign coord_sof   = (state == S_RUN) && (coord_x == 10'd0) && (coord_y == 9'd0);
  assign coord_eol   = (state == S_RUN) && last_x;
  assign busy        = (state != S_IDLE);
  assign frame_done  = (state == S_DONE);

  // State, coordinate and abort-request registers.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state     <= S_IDLE;
      coord_x   <= '0;
      coord_y   <= '0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      coord_x   <= x_nxt;
      coord_y   <= y_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  // Next-state, raster advance and abort handling.
  always_comb begin
    state_nxt     = state;
    x_nxt         = coord_x;
    y_nxt         = coord_y;
    stop_pend_nxt = stop_pend;
    case (state)
      S_IDLE: begin
        stop_pend_nxt = 1'b0;
        if (start) begin
          state_nxt = S_RUN;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      S_RUN: begin
        if (stop) stop_pend_nxt = 1'b1;
        if (issue) begin
          if (last_x) begin
            x_nxt = '0;
            if (last_y) begin
              y_nxt     = '0;
              state_nxt = S_DRAIN;
            end else begin
              y_nxt = coord_y + 9'd1;
            end
          end else begin
            x_nxt = coord_x + 10'd1;
          end
        end
        // Abort only when no offer is pending, so valid is never withdrawn.
        if (stop_pend && (!coord_valid || issue)) begin
          state_nxt = S_DRAIN;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      S_DRAIN: begin
        if (stop) stop_pend_nxt = 1'b1;
        if (inflight == '0) begin
          if (stop_pend) begin
            state_nxt     = S_IDLE;
            stop_pend_nxt = 1'b0;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        stop_pend_nxt = 1'b0;
        if (continuous && !stop && !stop_pend) begin
          state_nxt = S_RUN;
          x_nxt     = '0;
          y_nxt     = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Credit counter; a return with nothing outstanding flags a sticky error.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else if (issue && !credit_return) begin
      inflight <= inflight + CNT_W'(1);
    end else if (credit_return && !issue) begin
      if (inflight == '0) err_underflow <= 1'b1;
      else                inflight      <= inflight - CNT_W'(1);
    end
  end

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn)      frame_count <= '0;
    else if (state == S_DONE) frame_count <= frame_count + 16'd1;
  end

endmodule
